// File: rtl/rsa_operand_mac_if.sv
// rsa_operand_mac_if: start/busy/done handshake plus the two operand-memory
// read ports of the limb dot-product engine.
// Optional feature macro: RSA_MAC_ACCUM_EN adds the keep_acc request bit.
interface rsa_operand_mac_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int ACC_WIDTH  = 2*WIDTH + ADDR_WIDTH + 1
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH:0]   len;
`ifdef RSA_MAC_ACCUM_EN
    logic                  keep_acc;
`endif
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [WIDTH-1:0]      data_a;
    logic [WIDTH-1:0]      data_b;
    logic [ACC_WIDTH-1:0]  acc;
    logic                  busy;
    logic                  done;

    // Engine side
    modport slave (
`ifdef RSA_MAC_ACCUM_EN
        input  keep_acc,
`endif
        input  start, base_a, base_b, len, data_a, data_b,
        output addr_a, addr_b, acc, busy, done
    );

    // Requester / memory side
    modport master (
`ifdef RSA_MAC_ACCUM_EN
        output keep_acc,
`endif
        output start, base_a, base_b, len, data_a, data_b,
        input  addr_a, addr_b, acc, busy, done
    );
endinterface

// File: rtl/rsa_operand_mac.sv
// rsa_operand_mac: streams len limb pairs from two synchronous-read operand
// memories and accumulates sum(a[i]*b[i]) in a wide accumulator.
// Pipeline: address -> read data -> registered product -> accumulate.
// Optional feature macro: RSA_MAC_ACCUM_EN (keep_acc continues the previous sum).
// ACC_WIDTH must not be smaller than its default, which covers the worst case
// of 2**ADDR_WIDTH all-ones limb pairs without overflow.
module rsa_operand_mac #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int ACC_WIDTH  = 2*WIDTH + ADDR_WIDTH + 1
) (
    input  logic               clk,
    input  logic               reset,
    rsa_operand_mac_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_a_q, base_b_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0]   addr_b_q, addr_b_d;
    logic                    v_addr_q, v_addr_d;
    logic                    v_data_q;
    logic                    v_prod_q;
    logic [2*WIDTH-1:0]      prod_q;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic                    busy_q, done_q;
    logic                    accept;
    logic                    clear_acc;
    logic                    keep;

`ifdef RSA_MAC_ACCUM_EN
    assign keep = bus.keep_acc;
`else
    assign keep = 1'b0;
`endif

    // Next-state, address issue and start acceptance
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        v_addr_d  = 1'b0;
        accept    = 1'b0;
        clear_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    clear_acc = ~keep;
                    if (bus.len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // First pair is issued straight from the inputs so
                        // its address is already on the bus in cycle 1.
                        state_d  = S_RUN;
                        addr_a_d = bus.base_a;
                        addr_b_d = bus.base_b;
                        v_addr_d = 1'b1;
                        cnt_d    = {{ADDR_WIDTH{1'b0}}, 1'b1};
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_a_d = base_a_q + cnt_q[ADDR_WIDTH-1:0];
                    addr_b_d = base_b_q + cnt_q[ADDR_WIDTH-1:0];
                    v_addr_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // The last product is folded in on the same edge we enter DONE.
                if (!v_addr_q && !v_data_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath pipeline and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_a_q <= '0;
            base_b_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            v_addr_q <= 1'b0;
            v_data_q <= 1'b0;
            v_prod_q <= 1'b0;
            prod_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            v_addr_q <= v_addr_d;
            v_data_q <= v_addr_q;
            v_prod_q <= v_data_q;
            busy_q   <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q   <= (state_d == S_DONE);
            if (accept) begin
                base_a_q <= bus.base_a;
                base_b_q <= bus.base_b;
                len_q    <= bus.len;
            end
            if (v_data_q) begin
                prod_q <= (2*WIDTH)'(bus.data_a) * (2*WIDTH)'(bus.data_b);
            end
            if (clear_acc) begin
                acc_q <= '0;
            end else if (v_prod_q) begin
                acc_q <= acc_q + ACC_WIDTH'(prod_q);
            end
        end
    end

    assign bus.addr_a = addr_a_q;
    assign bus.addr_b = addr_b_q;
    assign bus.acc    = acc_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule
